// File: rtl/regfile_wr_arbiter_if.sv
// Bundles the core writeback, debug write and register-file write signals of regfile_wr_arbiter.
// The slave modport is the arbiter's view; the master modport is the view of the core/debug side.
interface regfile_wr_arbiter_if #(
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          core_we;
  logic [4:0]    core_rd;
  logic [31:0]   core_wdata;
  logic          core_stall;
  logic          dbg_valid;
  logic [4:0]    dbg_rd;
  logic [31:0]   dbg_wdata;
  logic          dbg_ready;
  logic          dbg_pending;
  logic [LW-1:0] dbg_level;
  logic          rf_we;
  logic [4:0]    rf_rd;
  logic [31:0]   rf_wdata;

  modport master (
    output core_we, core_rd, core_wdata, dbg_valid, dbg_rd, dbg_wdata,
    input  core_stall, dbg_ready, dbg_pending, dbg_level, rf_we, rf_rd, rf_wdata
  );

  modport slave (
    input  core_we, core_rd, core_wdata, dbg_valid, dbg_rd, dbg_wdata,
    output core_stall, dbg_ready, dbg_pending, dbg_level, rf_we, rf_rd, rf_wdata
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between core writeback and a FIFO of debug writes,
// forcing a one-cycle core stall when debug writes starve. Optional macro: RF_ARB_BYPASS_EN.
module regfile_wr_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic                 clk,
  input logic                 reset,
  regfile_wr_arbiter_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {ARB_CORE, ARB_FORCE, ARB_HOLD} arb_state_e;

  arb_state_e    state_q, state_d;
  logic [36:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic [7:0]    starve_q, starve_d;
  logic          stall_q, stall_d;
  logic          ready_en_q;
  logic          empty, full, accept, push, pop, core_win, bypass;

  assign empty = (count_q == '0);
  assign full  = (count_q == LW'(DEPTH));

  assign bus.dbg_ready   = ready_en_q && !full;
  assign bus.dbg_pending = !empty;
  assign bus.dbg_level   = count_q;
  assign bus.core_stall  = stall_q;

  always_comb begin
    // reset gates the core path so the port stays idle while reset is held low
    core_win = reset && (state_q != ARB_FORCE) && bus.core_we && (bus.core_rd != 5'd0);
    pop      = !core_win && !empty;
    accept   = bus.dbg_valid && bus.dbg_ready && (bus.dbg_rd != 5'd0);
`ifdef RF_ARB_BYPASS_EN
    bypass   = accept && empty && !core_win;
`else
    bypass   = 1'b0;
`endif
    push     = accept && !bypass;

    bus.rf_we    = 1'b0;
    bus.rf_rd    = 5'd0;
    bus.rf_wdata = 32'd0;
    if (core_win) begin
      bus.rf_we    = 1'b1;
      bus.rf_rd    = bus.core_rd;
      bus.rf_wdata = bus.core_wdata;
    end else if (pop) begin
      bus.rf_we                   = 1'b1;
      {bus.rf_rd, bus.rf_wdata}   = mem_q[rd_ptr_q];
    end else if (bypass) begin
      bus.rf_we    = 1'b1;
      bus.rf_rd    = bus.dbg_rd;
      bus.rf_wdata = bus.dbg_wdata;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + LW'(1);
    else if (pop && !push) count_d = count_q - LW'(1);

    starve_d = starve_q;
    if (pop || empty || state_q == ARB_HOLD) starve_d = 8'd0;
    else if (starve_q < 8'(STARVE_LIMIT))    starve_d = starve_q + 8'd1;

    state_d = state_q;
    case (state_q)
      ARB_CORE:  if (starve_d == 8'(STARVE_LIMIT)) state_d = ARB_FORCE;
      ARB_FORCE: state_d = ARB_HOLD;
      ARB_HOLD:  state_d = ARB_CORE;
      default:   state_d = ARB_CORE;
    endcase
    stall_d = (state_d == ARB_FORCE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ARB_CORE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= 8'd0;
      stall_q    <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      stall_q    <= stall_d;
      ready_en_q <= 1'b1;
    end
  end

  // Entry storage carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.dbg_rd, bus.dbg_wdata};
  end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized and directed bench for regfile_wr_arbiter against a queue-based reference model.
module tb_regfile_wr_arbiter;
  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;
  localparam int LW           = $clog2(DEPTH) + 1;

  typedef logic [36:0] ent_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wr_arbiter_if #(.DEPTH(DEPTH)) bus();
  regfile_wr_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset_n), .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  ent_t        mq[$];
  int          m_starve;
  bit          m_force, m_hold, m_rdy;
  bit          e_we, e_pop, e_push, e_byp, e_ready;
  logic [4:0]  e_rd;
  logic [31:0] e_wd;

  task automatic model_reset();
    mq.delete();
    m_starve = 0; m_force = 0; m_hold = 0; m_rdy = 0;
  endtask

  task automatic model_eval();
    bit core_ok, accept;
    core_ok = reset_n && !m_force && bus.core_we && (bus.core_rd != 5'd0);
    e_ready = m_rdy && (mq.size() < DEPTH);
    accept  = bus.dbg_valid && e_ready && (bus.dbg_rd != 5'd0);
    e_pop   = !core_ok && (mq.size() > 0);
    e_byp   = 1'b0;
`ifdef RF_ARB_BYPASS_EN
    e_byp   = accept && (mq.size() == 0) && !core_ok;
`endif
    e_push  = accept && !e_byp;
    e_we = 0; e_rd = 0; e_wd = 0;
    if (core_ok) begin e_we = 1; e_rd = bus.core_rd; e_wd = bus.core_wdata; end
    else if (e_pop) begin e_we = 1; {e_rd, e_wd} = mq[0]; end
    else if (e_byp) begin e_we = 1; e_rd = bus.dbg_rd; e_wd = bus.dbg_wdata; end
  endtask

  task automatic model_update();
    bit was_empty, nf;
    if (!reset_n) begin model_reset(); return; end
    was_empty = (mq.size() == 0);
    if (e_pop) void'(mq.pop_front());
    if (e_push) mq.push_back({bus.dbg_rd, bus.dbg_wdata});
    if (e_pop || was_empty || m_hold) m_starve = 0;
    else if (m_starve < STARVE_LIMIT) m_starve++;
    nf = !m_force && !m_hold && (m_starve == STARVE_LIMIT);
    m_hold = m_force; m_force = nf; m_rdy = 1;
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drv(bit we, logic [4:0] crd, logic [31:0] cwd, bit v, logic [4:0] drd, logic [31:0] dwd);
    bus.core_we = we; bus.core_rd = crd; bus.core_wdata = cwd;
    bus.dbg_valid = v; bus.dbg_rd = drd; bus.dbg_wdata = dwd;
  endtask

  task automatic test_reset();
    reset_n = 0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      drv($urandom_range(0, 1), 5'($urandom), $urandom, $urandom_range(0, 1), 5'($urandom), $urandom);
      #3;
      n_chk++;
      if ({bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.core_stall, bus.dbg_ready, bus.dbg_pending, bus.dbg_level} !== 43'd0) begin
        n_fail++;
        $display("FAIL reset_idle: we=%0b rd=%0d wd=%h stall=%0b rdy=%0b pend=%0b lvl=%0d, want all zero",
                 bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.core_stall, bus.dbg_ready, bus.dbg_pending, bus.dbg_level);
      end
      tick();
    end
    drv(0, 0, 0, 0, 0, 0);
    reset_n = 1;
    #3;
    n_chk++;
    if (bus.dbg_ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: got %0b want 0", bus.dbg_ready); end
    tick();
    n_chk++;
    if (bus.dbg_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_edge: got %0b want 1", bus.dbg_ready); end
  endtask

  task automatic test_debug_drain();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: drv(0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
        1: drv(0, 0, 0, 1, 5'd6, 32'h12345678);
        default: drv(0, 0, 0, 0, 0, 0);
      endcase
      #3; model_eval();
      n_chk++;
      if ({bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.core_stall, bus.dbg_ready, bus.dbg_level} !==
          {e_we, e_rd, e_wd, m_force, e_ready, LW'(mq.size())}) begin
        n_fail++;
        $display("FAIL drain c%0d: got we=%0b rd=%0d wd=%h stall=%0b rdy=%0b lvl=%0d want we=%0b rd=%0d wd=%h stall=%0b rdy=%0b lvl=%0d",
                 i, bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.core_stall, bus.dbg_ready, bus.dbg_level,
                 e_we, e_rd, e_wd, m_force, e_ready, mq.size());
      end
      if (i == 1) begin
        n_chk++;
        if ({bus.rf_we, bus.rf_rd, bus.rf_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
          n_fail++; $display("FAIL drain_first: got we=%0b rd=%0d wd=%h want 1/5/deadbeef", bus.rf_we, bus.rf_rd, bus.rf_wdata);
        end
      end
      tick();
    end
    n_chk++;
    if (bus.dbg_level !== '0) begin n_fail++; $display("FAIL drain_level: got %0d want 0", bus.dbg_level); end
  endtask

  task automatic test_core_priority();
    int first_stall = -1;
    drv(1, 5'd10, $urandom, 1, 5'd7, 32'hA5A5A5A5);
    tick();
    for (int k = 1; k <= 12; k++) begin
      drv(1, 5'd10, $urandom, 0, 0, 0);
      #3; model_eval();
      n_chk++;
      if ({bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.core_stall, bus.dbg_level} !==
          {e_we, e_rd, e_wd, m_force, LW'(mq.size())}) begin
        n_fail++;
        $display("FAIL core_prio c%0d: got we=%0b rd=%0d wd=%h stall=%0b lvl=%0d want we=%0b rd=%0d wd=%h stall=%0b lvl=%0d",
                 k, bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.core_stall, bus.dbg_level,
                 e_we, e_rd, e_wd, m_force, mq.size());
      end
      if (bus.core_stall === 1'b1 && first_stall < 0) begin
        first_stall = k;
        n_chk++;
        if ({bus.rf_rd, bus.rf_wdata} !== {5'd7, 32'hA5A5A5A5}) begin
          n_fail++; $display("FAIL forced_pop: got rd=%0d wd=%h want 7/a5a5a5a5", bus.rf_rd, bus.rf_wdata);
        end
      end
      tick();
    end
    n_chk++;
    if (first_stall != STARVE_LIMIT + 1) begin
      n_fail++; $display("FAIL stall_cycle: got %0d want %0d", first_stall, STARVE_LIMIT + 1);
    end
  endtask

  task automatic test_full_x0();
    for (int i = 0; i < 6; i++) begin
      if (i < 5) drv(1, 5'd10, $urandom, 1, 5'($urandom_range(1, 31)), $urandom);
      else       drv(1, 5'd10, $urandom, 0, 0, 0);
      #3; model_eval();
      n_chk++;
      if ({bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.dbg_ready, bus.dbg_level} !==
          {e_we, e_rd, e_wd, e_ready, LW'(mq.size())}) begin
        n_fail++;
        $display("FAIL fill c%0d: got rd=%0d rdy=%0b lvl=%0d want rd=%0d rdy=%0b lvl=%0d",
                 i, bus.rf_rd, bus.dbg_ready, bus.dbg_level, e_rd, e_ready, mq.size());
      end
      if (i >= 4) begin
        n_chk++;
        if ({bus.dbg_ready, bus.dbg_level} !== {1'b0, LW'(DEPTH)}) begin
          n_fail++; $display("FAIL full_ready: got rdy=%0b lvl=%0d want 0/%0d", bus.dbg_ready, bus.dbg_level, DEPTH);
        end
      end
      tick();
    end
    for (int i = 0; i < 60 && mq.size() > 0; i++) begin
      drv(1, 5'd10, $urandom, 0, 0, 0);
      #3; model_eval();
      n_chk++;
      if ({bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.core_stall, bus.dbg_level} !==
          {e_we, e_rd, e_wd, m_force, LW'(mq.size())}) begin
        n_fail++;
        $display("FAIL full_drain c%0d: got rd=%0d wd=%h stall=%0b lvl=%0d want rd=%0d wd=%h stall=%0b lvl=%0d",
                 i, bus.rf_rd, bus.rf_wdata, bus.core_stall, bus.dbg_level, e_rd, e_wd, m_force, mq.size());
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, (i == 0), 5'd0, 32'hCAFEF00D);
      #3;
      n_chk++;
      if ({bus.rf_we, bus.dbg_level} !== {1'b0, LW'(0)}) begin
        n_fail++; $display("FAIL x0_push c%0d: got we=%0b lvl=%0d want 0/0", i, bus.rf_we, bus.dbg_level);
      end
      tick();
    end
  endtask

  task automatic test_core_x0();
    logic [31:0] d = $urandom;
    drv(1, 5'd10, $urandom, 1, 5'd9, d);
    tick();
    drv(1, 5'd0, $urandom, 0, 0, 0);
    #3;
    n_chk++;
    if ({bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.core_stall} !== {1'b1, 5'd9, d, 1'b0}) begin
      n_fail++;
      $display("FAIL core_x0: got we=%0b rd=%0d wd=%h stall=%0b want 1/9/%h/0", bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.core_stall, d);
    end
    tick();
    n_chk++;
    if (bus.dbg_level !== '0) begin n_fail++; $display("FAIL core_x0_level: got %0d want 0", bus.dbg_level); end
  endtask

  task automatic test_async_reset();
    bit hit = 0;
    for (int i = 0; i < 3; i++) begin
      drv(1, 5'd10, $urandom, 1, 5'($urandom_range(1, 31)), $urandom);
      tick();
    end
    for (int i = 0; i < 40 && !hit; i++) begin
      drv(1, 5'd10, $urandom, 0, 0, 0);
      if (bus.core_stall === 1'b1) hit = 1;
      else tick();
    end
    n_chk++;
    if (!hit) begin n_fail++; $display("FAIL force_wait: got no stall within 40 cycles, want stall"); end
    n_chk++;
    if (bus.dbg_level !== LW'(3)) begin n_fail++; $display("FAIL force_level: got %0d want 3", bus.dbg_level); end
    reset_n = 0;
    model_reset();
    #1;
    n_chk++;
    if ({bus.core_stall, bus.dbg_level, bus.rf_we, bus.dbg_ready} !== {1'b0, LW'(0), 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got stall=%0b lvl=%0d we=%0b rdy=%0b want 0/0/0/0", bus.core_stall, bus.dbg_level, bus.rf_we, bus.dbg_ready);
    end
    #2;
    tick(); tick();
    reset_n = 1;
    for (int i = 0; i < 10; i++) begin
      drv(0, 0, 0, 0, 0, 0);
      #3;
      n_chk++;
      if ({bus.rf_we, bus.dbg_level} !== {1'b0, LW'(0)}) begin
        n_fail++; $display("FAIL stale_write c%0d: got we=%0b rd=%0d lvl=%0d want we=0 lvl=0", i, bus.rf_we, bus.rf_rd, bus.dbg_level);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drv($urandom_range(0, 9) < 8, 5'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 31)), $urandom,
          $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 31)), $urandom);
      #3; model_eval();
      n_chk++;
      if ({bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.core_stall, bus.dbg_ready, bus.dbg_pending, bus.dbg_level} !==
          {e_we, e_rd, e_wd, m_force, e_ready, (mq.size() != 0), LW'(mq.size())}) begin
        n_fail++;
        $display("FAIL random c%0d: got we=%0b rd=%0d wd=%h stall=%0b rdy=%0b lvl=%0d want we=%0b rd=%0d wd=%h stall=%0b rdy=%0b lvl=%0d",
                 i, bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.core_stall, bus.dbg_ready, bus.dbg_level,
                 e_we, e_rd, e_wd, m_force, e_ready, mq.size());
      end
      tick();
    end
  endtask

  initial begin
    drv(0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_debug_drain();
    test_core_priority();
    test_full_x0();
    test_core_x0();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Owns the single register-file write port and shares it between two requesters:
  - the core writeback path, which is single-cycle and normally has priority;
  - a debug/loader requester, which pushes register writes through a ready/valid handshake into a small FIFO.
- A starvation counter forces a one-cycle core stall so that queued debug writes always drain.
- Sits between the decode/writeback stage and the register file; drives the file's rd select, write enable and write data.

Parameters:
- DEPTH, 4, debug write FIFO entries; power of two, 2..16.
- STARVE_LIMIT, 8, consecutive cycles a non-empty FIFO may go unserved before a forced stall; 1..255.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- core_we  in  1  core writeback wants the write port this cycle.
- core_rd  in  5  core destination register.
- core_wdata  in  32  core writeback data.
- core_stall  out  1  registered; core must hold PC and not retire while high.
- dbg_valid  in  1  debug write request.
- dbg_rd  in  5  debug destination register.
- dbg_wdata  in  32  debug write data.
- dbg_ready  out  1  FIFO can accept; equals not-full.
- rf_we  out  1  register-file write enable.
- rf_rd  out  5  register-file destination select.
- rf_wdata  out  32  register-file write data.
- dbg_pending  out  1  FIFO non-empty.
- dbg_level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low. While reset is low:
  - FIFO emptied, pointers 0, starvation counter 0, state ARB_CORE;
  - core_stall=0, dbg_ready=0, dbg_pending=0, dbg_level=0.
  - rf_we/rf_rd/rf_wdata are combinational and follow the reset state: rf_we=0, rf_rd=0, rf_wdata=0.
  - dbg_ready rises on the first clk edge after reset deasserts.
- Push: dbg_valid && dbg_ready at a rising edge enqueues {dbg_rd, dbg_wdata}. Writes with dbg_rd=0 are accepted but discarded; they never occupy an entry.
- Port select is combinational, same cycle:
  - Core wins when state is ARB_CORE and core_we=1 and core_rd!=0: rf_we=1, rf_rd=core_rd, rf_wdata=core_wdata.
  - Otherwise, if the FIFO is non-empty: drive the head entry with rf_we=1, and pop at the edge.
  - Otherwise rf_we=0, rf_rd=0, rf_wdata=0.
- core_we with core_rd=0 never drives the port; a debug pop may use that cycle.
- Simultaneous push and pop: allowed, and dbg_level is unchanged.
  - Pushing into an empty FIFO does not pop in the same cycle (no bypass; see Optional Feature).
  - A push to a full FIFO is impossible because dbg_ready=0.
- Ordering: debug writes retire in push order. The core and debug streams have no mutual ordering guarantee; the last write to land wins.
- Starvation counter (8-bit):
  - increments each cycle the FIFO is non-empty and no pop occurs;
  - clears on any pop, or when the FIFO is empty;
  - saturates at STARVE_LIMIT.
- State machine:
  - ARB_CORE: when the counter reaches STARVE_LIMIT at an edge, go to ARB_FORCE and set core_stall=1 at that edge.
  - ARB_FORCE: lasts one cycle. core_stall=1, core_we is ignored, and the head entry is popped. Next state is ARB_HOLD and core_stall returns to 0.
  - ARB_HOLD: lasts one cycle and the core has priority. The counter is held at 0. Next state is ARB_CORE.
- Guaranteed worst-case service: a FIFO head is written within STARVE_LIMIT+1 cycles of becoming head, except when it becomes head during ARB_HOLD, which adds one cycle.
- Reset mid-operation: every queued entry is lost. core_stall drops immediately (asynchronously).

Optional Feature:
- Macro: RF_ARB_BYPASS_EN.
- Defined: when the FIFO is empty, dbg_valid=1, dbg_rd!=0 and the core is not using the port, the debug write drives rf_* in the same cycle and is not enqueued (zero latency). dbg_ready stays not-full.
- Undefined: every debug write goes through the FIFO. Minimum latency from push edge to rf_we is 1 cycle.

Test Plan:
- Reset then idle:
  - Stimulus: hold reset low for 3 cycles with random inputs.
  - Response: rf_we=0, core_stall=0, dbg_ready=0, dbg_level=0. After release, dbg_ready=1 on the first edge.
- Debug-only drain:
  - Stimulus: push (x5, 0xDEADBEEF) then (x6, 0x12345678); core_we=0.
  - Response: rf_we=1 with rf_rd=5 the cycle after the first push, then rf_rd=6. dbg_level returns to 0.
- Core priority:
  - Stimulus: core_we=1 with core_rd=10 every cycle; push (x7, 0xA5A5A5A5).
  - Response: rf_rd=10 for 8 cycles. core_stall=1 on the next cycle, with rf_rd=7 and rf_wdata=0xA5A5A5A5. The cycle after, core_stall=0 and rf_rd=10.
- Full/x0 handling:
  - Stimulus: with core saturating, push 4 entries, then attempt a 5th; separately push to x0.
  - Response: dbg_ready=0 once dbg_level=4. The x0 push leaves dbg_level unchanged and never produces rf_we.
- Core x0 slot reuse:
  - Stimulus: core_we=1 with core_rd=0 while 1 entry is pending.
  - Response: the debug entry is written in that cycle and core_stall stays 0.
- Async reset mid-stall:
  - Stimulus: drop reset during ARB_FORCE with 3 entries queued.
  - Response: core_stall=0 and dbg_level=0 immediately. After release, no stale writes appear.
